// File: rtl/memory_dff_rd2_fwd.sv
// memory_dff_rd2_fwd: one-write, two-read flop memory with post-reset clear FSM; MEMORY_DFF_RD2_FWD_BYPASS_EN selects write-first reads.
module memory_dff_rd2_fwd #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re1,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd1,
  output logic          rv1,
  input  logic          re2,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd2,
  output logic          rv2,
  output logic          busy
);
  typedef enum logic {S_CLEAR, S_READY} state_t;
  state_t        r_state, w_next;
  logic [AW-1:0] r_ptr;
  logic [DW-1:0] r_mem [2**AW];
  logic          w_fwd1, w_fwd2;
`ifdef MEMORY_DFF_RD2_FWD_BYPASS_EN
  assign w_fwd1 = we && (wa == ra1);
  assign w_fwd2 = we && (wa == ra2);
`else
  assign w_fwd1 = 1'b0;
  assign w_fwd2 = 1'b0;
`endif
  always_ff @(posedge clk)
    r_state <= rst ? S_CLEAR : w_next;
  always_comb
    w_next = (r_state == S_CLEAR && r_ptr == {AW{1'b1}}) ? S_READY : r_state;
  always_comb
    busy = (r_state == S_CLEAR);
  always_ff @(posedge clk)
    if (rst) r_ptr <= '0;
    else if (busy) r_ptr <= AW'(r_ptr + 1'b1);
  // Reset leaves contents alone; the clear pass that follows zeroes them.
  always_ff @(posedge clk)
    if (!rst) begin
      if (busy) r_mem[r_ptr] <= '0;
      else if (we) r_mem[wa] <= wd;
    end
  always_ff @(posedge clk)
    if (rst || busy) begin
      rd1 <= '0;
      rv1 <= 1'b0;
      rd2 <= '0;
      rv2 <= 1'b0;
    end else begin
      rv1 <= re1;
      rv2 <= re2;
      if (re1) rd1 <= w_fwd1 ? wd : r_mem[ra1];
      if (re2) rd2 <= w_fwd2 ? wd : r_mem[ra2];
    end
endmodule

// File: tb/tb_memory_dff_rd2_fwd.sv
// tb_memory_dff_rd2_fwd: directed self-checking bench for memory_dff_rd2_fwd.
module tb_memory_dff_rd2_fwd;
  logic       clk = 0, rst = 0, we = 0, re1 = 0, re2 = 0;
  logic [3:0] wa = 0, wd = 0, ra1 = 0, ra2 = 0;
  logic [3:0] rd1, rd2;
  logic       rv1, rv2, busy;
  int         vec = 0, miss = 0, n;
  memory_dff_rd2_fwd dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .re1(re1), .ra1(ra1), .rd1(rd1), .rv1(rv1),
    .re2(re2), .ra2(ra2), .rd2(rd2), .rv2(rv2), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic count_busy(input string tag);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick;
      n++;
    end
    chk(tag, n, 16);
  endtask
  initial begin
    rst = 1;
    tick;
    rst = 0;
    chk("rst_busy", busy, 1);
    chk("rst_rv1", rv1, 0);
    chk("rst_rd1", rd1, 0);
    chk("rst_rv2", rv2, 0);
    chk("rst_rd2", rd2, 0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      we = (n == 10); wa = 3; wd = 4'hA;
      re1 = (n == 10); ra1 = 3;
      tick;
      n++;
      if (n == 11) begin
        chk("clr_rv1", rv1, 0);
        chk("clr_rd1", rd1, 0);
      end
    end
    we = 0; re1 = 0;
    chk("busy_len", n, 16);
    for (int a = 0; a < 16; a++) begin
      re1 = 1; ra1 = 4'(a);
      tick;
      chk($sformatf("zero_rd1_%0d", a), rd1, 0);
      chk($sformatf("zero_rv1_%0d", a), rv1, 1);
    end
    re1 = 0;
    we = 1; wa = 5; wd = 4'hC;
    tick;
    we = 0; re1 = 1; ra1 = 5; re2 = 1; ra2 = 5;
    tick;
    chk("basic_rd1", rd1, 4'hC);
    chk("basic_rd2", rd2, 4'hC);
    chk("basic_rv1", rv1, 1);
    chk("basic_rv2", rv2, 1);
    re1 = 0; re2 = 0;
    tick;
    chk("idle_rv1", rv1, 0);
    chk("idle_rv2", rv2, 0);
    chk("hold_rd1", rd1, 4'hC);
    chk("hold_rd2", rd2, 4'hC);
    we = 1; wa = 7; wd = 4'h2;
    tick;
    wa = 6; wd = 4'h1;
    tick;
    wa = 7; wd = 4'h9; re1 = 1; ra1 = 7; re2 = 1; ra2 = 6;
    tick;
    we = 0;
    chk("coll_rd2", rd2, 4'h1);
    chk("coll_rv1", rv1, 1);
    chk("coll_rv2", rv2, 1);
`ifdef MEMORY_DFF_RD2_FWD_BYPASS_EN
    chk("coll_rd1", rd1, 4'h9);
`else
    chk("coll_rd1", rd1, 4'h2);
`endif
    re2 = 0; ra1 = 7;
    tick;
    re1 = 0;
    chk("after_coll_rd1", rd1, 4'h9);
    rst = 1;
    tick;
    rst = 0;
    for (int i = 0; i < 8; i++) tick;
    chk("midclr_busy", busy, 1);
    rst = 1;
    tick;
    rst = 0;
    count_busy("midclr_len");
    we = 1; wa = 0; wd = 4'hF;
    tick;
    re1 = 1; ra1 = 0; we = 0;
    tick;
    chk("pre_rst_rd1", rd1, 4'hF);
    re1 = 0;
    rst = 1; we = 1; wa = 1; wd = 4'hE;
    tick;
    rst = 0; we = 0;
    chk("ready_rst_rd1", rd1, 0);
    chk("ready_rst_rv1", rv1, 0);
    count_busy("ready_rst_len");
    re1 = 1; ra1 = 0; re2 = 1; ra2 = 1;
    tick;
    re1 = 0; re2 = 0;
    chk("cleared_addr0", rd1, 0);
    chk("dropped_write", rd2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/memory_dff_rd2_fwd.md
Name: memory_dff_rd2_fwd

Overview:
- Small flop-based memory: one write port, two independent read ports with registered outputs and read valid strobes.
- Complements the team's multi-write, single-read DFF memory: one writer, two readers.
- A built-in clear FSM zeroes every entry after reset, so contents are defined before first use.
- Used in opt-pass test structures where read/write collision and transparency handling must be exercised from the read side.

Parameters:
- AW, 4, address width; depth = 2**AW entries.
- DW, 4, data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-high.
- we  input  1  write enable.
- wa  input  AW  write address.
- wd  input  DW  write data.
- re1  input  1  read enable, port 1.
- ra1  input  AW  read address, port 1.
- rd1  output  DW  registered read data, port 1.
- rv1  output  1  read valid strobe, port 1.
- re2  input  1  read enable, port 2.
- ra2  input  AW  read address, port 2.
- rd2  output  DW  registered read data, port 2.
- rv2  output  1  read valid strobe, port 2.
- busy  output  1  clear FSM active; the memory does not accept accesses.

Behaviour:
- Reset (rst=1 at posedge):
  - state <= CLEAR, clear pointer <= 0.
  - rd1, rd2 <= 0; rv1, rv2 <= 0; busy <= 1.
  - Memory contents are not touched by reset itself.
- State CLEAR:
  - Each cycle: mem[ptr] <= 0, then ptr <= ptr+1.
  - The write that clears ptr == 2**AW-1 moves state to READY. busy is 0 from the following cycle.
  - busy is therefore high for exactly 2**AW cycles after rst deasserts (16 cycles at defaults).
  - User we, re1 and re2 are ignored. rd1/rd2 hold 0 and rv1/rv2 stay 0.
- State READY:
  - Write: we=1 gives mem[wa] <= wd at the edge.
  - Read port n: ren=1 at edge k gives rdn <= mem[ran] and rvn <= 1, both visible after edge k (1-cycle latency).
  - ren=0 gives rvn <= 0 and rdn holds its previous value.
- Port independence:
  - Both ports may read the same or different addresses in the same cycle; each port returns the correct data independently.
- Read-during-write (ren=1, we=1, ran==wa, same edge): see Optional Feature. This applies to each port independently.
- Reset mid-operation:
  - rst during CLEAR restarts the clear from ptr=0.
  - rst during READY aborts everything; a write presented in the same cycle as rst is dropped.
  - Entries are re-zeroed by the new CLEAR pass.
- rst has priority over every other input.
- Address wrap: the clear pointer is AW bits wide, and its termination is decided by comparison to all-ones, not by overflow.

Optional Feature:
- Macro: MEMORY_DFF_RD2_FWD_BYPASS_EN.
- Defined (write-first): on a same-address read-during-write, rdn <= wd, the new data.
- Undefined (read-first): rdn <= the old mem[ran].
- In both modes mem[wa] is updated, and the strobe rvn <= 1 is unchanged.

Test Plan:
- Reset then idle: rst high 1 cycle, then low.
  - busy=1 for exactly 16 cycles, then 0.
  - Reading every address 0..15 on port 1 returns rd1=0 with rv1=1 one cycle after each request.
- Access during clear: write wa=3, wd=4'hA and read ra1=3 while busy=1.
  - Ignored; rv1=0, rd1=0.
  - After busy falls, a read of addr 3 returns 4'h0.
- Basic write/read: write wa=5, wd=4'hC; next cycle re1=1 ra1=5 and re2=1 ra2=5.
  - One cycle later rd1=rd2=4'hC and rv1=rv2=1.
  - With re1=re2=0 the cycle after, rv1=rv2=0 and rd holds 4'hC.
- Collision: mem[7]=4'h2; same cycle we=1 wa=7 wd=4'h9, re1=1 ra1=7, re2=1 ra2=6 (mem[6]=4'h1).
  - rd2=4'h1 in both builds.
  - rd1=4'h9 with MEMORY_DFF_RD2_FWD_BYPASS_EN defined, 4'h2 without.
  - A later read of addr 7 returns 4'h9 in both builds.
- Reset mid-clear: assert rst again at clear cycle 8.
  - busy stays high 16 more cycles from the new deassertion.
- Reset in READY: write 4'hF to addr 0, then pulse rst.
  - After the clear completes, a read of addr 0 returns 4'h0.
  - A write presented in the rst cycle has no effect.
